icache_responder: RTL

ICACHE_RESPONDER -- requirements
Module: icache_responder

---
 rtl/icache_responder_pkg.sv | 26 ++
 rtl/icache_responder_if.sv | 32 +++
 rtl/icache_refill_fsm.sv | 87 ++++++++
 rtl/icache_responder.sv | 110 +++++++++++
 4 files changed

// File: rtl/icache_responder_pkg.sv
// Shared types for the instruction-cache responder: refill FSM states and
// the halfword-count encoding reported on partial_type.
package icache_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } refill_state_e;

  localparam logic [1:0] PT_NONE  = 2'b00;
  localparam logic [1:0] PT_ONE   = 2'b01;
  localparam logic [1:0] PT_TWO   = 2'b10;
  localparam logic [1:0] PT_THREE = 2'b11;

  // Halfwords left before the line end -> partial_type code.
  function automatic logic [1:0] partial_code(input int hw_left);
    case (hw_left)
      1:       return PT_ONE;
      2:       return PT_TWO;
      3:       return PT_THREE;
      default: return PT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/icache_responder_if.sv
// Fetch-side lookup and memory-side refill signals of the instruction cache.
// slave = cache, master = fetch stage / memory / bench.
interface icache_responder_if #(
  parameter int PC_BITS     = 32,
  parameter int FETCH_WIDTH = 64,
  parameter int BEAT_BITS   = 64
);
  logic [PC_BITS-1:0]     current_pc;
  logic                   hit_cache;
  logic                   miss;
  logic                   partial_access;
  logic [1:0]             partial_type;
  logic [FETCH_WIDTH-1:0] fetched_data;
  logic                   invalidate_all;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [PC_BITS-1:0]     mem_req_addr;
  logic                   mem_resp_valid;
  logic [BEAT_BITS-1:0]   mem_resp_data;

  modport slave (
    input  current_pc, invalidate_all, mem_req_ready, mem_resp_valid, mem_resp_data,
    output hit_cache, miss, partial_access, partial_type, fetched_data,
           mem_req_valid, mem_req_addr
  );

  modport master (
    output current_pc, invalidate_all, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  hit_cache, miss, partial_access, partial_type, fetched_data,
           mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/icache_refill_fsm.sv
// Line refill sequencer: one request handshake, then a fixed number of beats
// assembled into a line buffer; the last beat is forwarded merged.
//   state   | meaning
//   ST_IDLE | lookups served, waiting for a miss
//   ST_REQ  | mem_req_valid held with latched line address until ready
//   ST_RESP | collecting beats; last beat writes the array
module icache_refill_fsm
  import icache_responder_pkg::*;
#(
  parameter int PC_BITS   = 32,
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [PC_BITS-1:0]   line_addr,
  input  logic                 invalidate_all,
  input  logic                 mem_req_ready,
  input  logic                 mem_resp_valid,
  input  logic [BEAT_BITS-1:0] mem_resp_data,
  output logic                 idle,
  output logic                 mem_req_valid,
  output logic [PC_BITS-1:0]   req_addr,
  output logic                 fill_we,
  output logic                 fill_set_valid,
  output logic [LINE_BITS-1:0] fill_line
);

  localparam int NUM_BEATS = LINE_BITS / BEAT_BITS;
  localparam int CNT_BITS  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  refill_state_e        state_q, state_d;
  logic [CNT_BITS-1:0]  beat_cnt;
  logic                 stale_q;
  logic [LINE_BITS-1:0] line_buf;
  logic                 beat_fire;
  logic                 last_beat;

  assign beat_fire = (state_q == ST_RESP) && mem_resp_valid;
  assign last_beat = beat_cnt == CNT_BITS'(NUM_BEATS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start)                  state_d = ST_REQ;
      ST_REQ:  if (mem_req_ready)          state_d = ST_RESP;
      ST_RESP: if (beat_fire && last_beat) state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idle           = state_q == ST_IDLE;
    mem_req_valid  = state_q == ST_REQ;
    fill_we        = beat_fire && last_beat;
    // A fence seen at any point of the refill, including its last beat, keeps the line invalid.
    fill_set_valid = !stale_q && !invalidate_all;
    fill_line      = line_buf;
    fill_line[int'(beat_cnt) * BEAT_BITS +: BEAT_BITS] = mem_resp_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr <= '0;
      beat_cnt <= '0;
      stale_q  <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      req_addr <= line_addr;
      beat_cnt <= '0;
      stale_q  <= 1'b0;
    end else begin
      if (invalidate_all && state_q != ST_IDLE) stale_q <= 1'b1;
      if (beat_fire) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_fire) line_buf[int'(beat_cnt) * BEAT_BITS +: BEAT_BITS] <= mem_resp_data;
  end

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache: same-cycle lookup returning a halfword-aligned
// fetch window, truncated at the line end, with a single-line refill engine.
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int PC_BITS     = 32,
  parameter int FETCH_WIDTH = 64,
  parameter int LINE_BITS   = 256,
  parameter int ENTRIES     = 64,
  parameter int BEAT_BITS   = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  icache_responder_if.slave  bus
);

  localparam int OFF_BITS = $clog2(LINE_BITS / 8);
  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = PC_BITS - OFF_BITS - IDX_BITS;
  localparam int LINE_HW  = LINE_BITS / 16;
  localparam int FETCH_HW = FETCH_WIDTH / 16;

  logic [LINE_BITS-1:0] data_mem [ENTRIES];
  logic [TAG_BITS-1:0]  tag_mem  [ENTRIES];
  logic [ENTRIES-1:0]   valid_q;

  logic [IDX_BITS-1:0]   idx;
  logic [TAG_BITS-1:0]   tag;
  logic [OFF_BITS-2:0]   hw_off;
  logic [PC_BITS-1:0]    line_addr;
  logic                  unused_pc_bit0;
  logic                  tag_hit;
  logic                  hit;
  int                    hw_left;
  logic [LINE_BITS-1:0]  line_shift;

  logic                  fsm_idle;
  logic                  req_valid;
  logic [PC_BITS-1:0]    req_addr;
  logic                  fill_we;
  logic                  fill_set_valid;
  logic [LINE_BITS-1:0]  fill_line;
  logic [IDX_BITS-1:0]   fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;

  assign idx            = bus.current_pc[OFF_BITS +: IDX_BITS];
  assign tag            = bus.current_pc[PC_BITS-1 -: TAG_BITS];
  assign hw_off         = bus.current_pc[OFF_BITS-1:1];
  assign unused_pc_bit0 = bus.current_pc[0];
  assign line_addr      = {bus.current_pc[PC_BITS-1:OFF_BITS], {OFF_BITS{1'b0}}};
  assign tag_hit        = valid_q[idx] && (tag_mem[idx] == tag);
  assign fill_idx       = req_addr[OFF_BITS +: IDX_BITS];
  assign fill_tag       = req_addr[PC_BITS-1 -: TAG_BITS];

  icache_refill_fsm #(
    .PC_BITS   (PC_BITS),
    .LINE_BITS (LINE_BITS),
    .BEAT_BITS (BEAT_BITS)
  ) u_refill (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (!tag_hit),
    .line_addr      (line_addr),
    .invalidate_all (bus.invalidate_all),
    .mem_req_ready  (bus.mem_req_ready),
    .mem_resp_valid (bus.mem_resp_valid),
    .mem_resp_data  (bus.mem_resp_data),
    .idle           (fsm_idle),
    .mem_req_valid  (req_valid),
    .req_addr       (req_addr),
    .fill_we        (fill_we),
    .fill_set_valid (fill_set_valid),
    .fill_line      (fill_line)
  );

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = req_addr;

  always_comb begin
    hit                = fsm_idle && tag_hit;
    hw_left            = LINE_HW - int'(hw_off);
    line_shift         = data_mem[idx] >> (16 * int'(hw_off));
    bus.hit_cache      = hit;
    bus.miss           = !hit;
    bus.partial_access = 1'b0;
    bus.partial_type   = PT_NONE;
    bus.fetched_data   = '0;
    if (hit) begin
      bus.fetched_data = line_shift[FETCH_WIDTH-1:0];
      if (hw_left < FETCH_HW) begin
        bus.partial_access = 1'b1;
        bus.partial_type   = partial_code(hw_left);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  valid_q <= '0;
    else if (bus.invalidate_all) valid_q <= '0;
    else if (fill_we)            valid_q[fill_idx] <= fill_set_valid;
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[fill_idx] <= fill_line;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

endmodule
